// File: rtl/spi_pkg.sv
// Shared SPI definitions: spi_cr1 bit indices and the request-arbiter state encoding.
// Ports: none (package).
package spi_pkg;

    // spi_cr1 bit positions
    localparam int unsigned CR1_SPE     = 7;
    localparam int unsigned CR1_MTSR    = 6;
    localparam int unsigned CR1_CPOL    = 5;
    localparam int unsigned CR1_CPHA    = 4;
    localparam int unsigned CR1_SSOE    = 3;
    localparam int unsigned CR1_LSBFE   = 2;
    localparam int unsigned CR1_MODFEN  = 1;
    localparam int unsigned CR1_SPISWAI = 0;

    localparam int unsigned CR1_W = 8;

    // Bits the arbiter always sets: core enabled, master mode
    localparam logic [CR1_W-1:0] CR1_FORCE = CR1_W'((1 << CR1_SPE) | (1 << CR1_MTSR));

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_START = 3'd2,
        ST_BUSY  = 3'd3,
        ST_DONE  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
// Ports: req (request vector), ptr (start index), gnt (one-hot winner, 0 if none),
//        idx (winner index).
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [2*N-1:0] rot;
    logic [IW:0]    off;
    logic [IW:0]    sum;
    logic           found;

    // Rotate so bit 0 is req[ptr]; scan downward so the lowest offset wins.
    always_comb begin
        rot   = {req, req} >> ptr;
        off   = '0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off   = (IW+1)'(k);
                found = 1'b1;
            end
        end
        sum = {1'b0, ptr} + off;
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        idx = sum[IW-1:0];
        gnt = found ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin scheduler sharing one spi_master between NUM_REQ requesters.
// Ports: clk_in/rst_in (sync active-high reset); req_in/last_in/data_in/cr1_in per
//        requester; gnt_out/ack_out/err_out per requester; rx_data_out received byte;
//        new_tx_out/finished_in/master_rx_in/tx_data_out/spi_cr1_out master handshake;
//        ss_n_out active-low slave selects.
module spi_req_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [NUM_REQ-1:0]          req_in,
    input  logic [NUM_REQ-1:0]          last_in,
    input  logic [NUM_REQ*DATA_W-1:0]   data_in,
    input  logic [NUM_REQ*CR1_W-1:0]    cr1_in,
    output logic [NUM_REQ-1:0]          gnt_out,
    output logic [NUM_REQ-1:0]          ack_out,
    output logic [NUM_REQ-1:0]          err_out,
    output logic [DATA_W-1:0]           rx_data_out,
    output logic                        new_tx_out,
    input  logic                        finished_in,
    input  logic [DATA_W-1:0]           master_rx_in,
    output logic [DATA_W-1:0]           tx_data_out,
    output logic [CR1_W-1:0]            spi_cr1_out,
    output logic [NUM_REQ-1:0]          ss_n_out
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned SW = 4;

    arb_state_t state_q, state_d;

    logic [NUM_REQ-1:0] gnt_q, gnt_d, ss_n_q, ss_n_d, ack_q, ack_d, err_q, err_d;
    logic [IW-1:0]      owner_q, owner_d, ptr_q, ptr_d, next_ptr;
    logic [DATA_W-1:0]  tx_q, tx_d, rx_q, rx_d, data_own;
    logic [CR1_W-1:0]   cr1_q, cr1_d, cr1_pick;
    logic [SW-1:0]      setup_cnt_q, setup_cnt_d;
    logic [TW-1:0]      to_cnt_q, to_cnt_d;
    logic               new_tx_q, new_tx_d, last_q, last_d;
    logic               req_own, last_own, setup_done, timeout_hit;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req (req_in),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Per-requester field selection for the pick candidate and the current owner
    always_comb begin
        cr1_pick = '0;
        data_own = '0;
        req_own  = 1'b0;
        last_own = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                cr1_pick = cr1_in[i*CR1_W +: CR1_W];
            end
            if (owner_q == IW'(i)) begin
                data_own = data_in[i*DATA_W +: DATA_W];
                req_own  = req_in[i];
                last_own = last_in[i];
            end
        end
    end

    assign next_ptr    = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
    assign setup_done  = (setup_cnt_q == SW'(SETUP_CYC - 1));
    // Fires on the edge the counter would reach TIMEOUT
    assign timeout_hit = (to_cnt_q == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (|req_in) state_d = ST_SETUP;
            ST_SETUP: begin
                if (!req_own) begin
                    state_d = ST_IDLE;
                end else if (setup_done) begin
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_BUSY;
            ST_BUSY: begin
                if (finished_in) begin
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE:  state_d = (!last_q && req_own) ? ST_START : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; pulses default low
    always_comb begin
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        ss_n_d      = ss_n_q;
        ack_d       = '0;
        err_d       = '0;
        new_tx_d    = 1'b0;
        tx_d        = tx_q;
        rx_d        = rx_q;
        cr1_d       = cr1_q;
        setup_cnt_d = setup_cnt_q;
        to_cnt_d    = to_cnt_q;
        last_d      = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_in) begin
                    gnt_d       = pick_gnt;
                    owner_d     = pick_idx;
                    ss_n_d      = ~pick_gnt;
                    cr1_d       = cr1_pick | CR1_FORCE;
                    setup_cnt_d = '0;
                end
            end
            ST_SETUP: begin
                if (!req_own) begin
                    gnt_d  = '0;
                    ss_n_d = '1;
                end else begin
                    setup_cnt_d = setup_cnt_q + SW'(1);
                end
            end
            ST_START: begin
                tx_d     = data_own;
                new_tx_d = 1'b1;
                to_cnt_d = '0;
                last_d   = last_own;
            end
            ST_BUSY: begin
                to_cnt_d = (to_cnt_q == {TW{1'b1}}) ? to_cnt_q : to_cnt_q + TW'(1);
                if (finished_in) begin
                    rx_d  = master_rx_in;
                    ack_d = gnt_q;
                end else if (timeout_hit) begin
                    err_d  = gnt_q;
                    gnt_d  = '0;
                    ss_n_d = '1;
                    ptr_d  = next_ptr;
                end
            end
            ST_DONE: begin
                if (last_q || !req_own) begin
                    gnt_d  = '0;
                    ss_n_d = '1;
                    ptr_d  = next_ptr;
                end
            end
            default: ;
        endcase
    end

    // Output/datapath registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            gnt_q       <= '0;
            owner_q     <= '0;
            ptr_q       <= '0;
            ss_n_q      <= '1;
            ack_q       <= '0;
            err_q       <= '0;
            new_tx_q    <= 1'b0;
            tx_q        <= '0;
            rx_q        <= '0;
            cr1_q       <= '0;
            setup_cnt_q <= '0;
            to_cnt_q    <= '0;
            last_q      <= 1'b0;
        end else begin
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            ss_n_q      <= ss_n_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            new_tx_q    <= new_tx_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            cr1_q       <= cr1_d;
            setup_cnt_q <= setup_cnt_d;
            to_cnt_q    <= to_cnt_d;
            last_q      <= last_d;
        end
    end

    assign gnt_out     = gnt_q;
    assign ack_out     = ack_q;
    assign err_out     = err_q;
    assign rx_data_out = rx_q;
    assign new_tx_out  = new_tx_q;
    assign tx_data_out = tx_q;
    assign spi_cr1_out = cr1_q;
    assign ss_n_out    = ss_n_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Self-checking bench for spi_req_arbiter (4 requesters, SETUP_CYC=2, TIMEOUT=15).
module tb_spi_req_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [3:0]  req_in, last_in;
    logic [31:0] data_in, cr1_in;
    logic [3:0]  gnt_out, ack_out, err_out, ss_n_out;
    logic [7:0]  rx_data_out, tx_data_out, spi_cr1_out, master_rx_in;
    logic        new_tx_out, finished_in;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk_in = ~clk_in;

    spi_req_arbiter #(
        .NUM_REQ   (4),
        .DATA_W    (8),
        .SETUP_CYC (2),
        .TIMEOUT   (15)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .req_in       (req_in),
        .last_in      (last_in),
        .data_in      (data_in),
        .cr1_in       (cr1_in),
        .gnt_out      (gnt_out),
        .ack_out      (ack_out),
        .err_out      (err_out),
        .rx_data_out  (rx_data_out),
        .new_tx_out   (new_tx_out),
        .finished_in  (finished_in),
        .master_rx_in (master_rx_in),
        .tx_data_out  (tx_data_out),
        .spi_cr1_out  (spi_cr1_out),
        .ss_n_out     (ss_n_out)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] last;
        logic       fin;
        logic [7:0] mrx;
        logic [3:0] e_gnt;
        logic [3:0] e_ss;
        logic [3:0] e_ack;
        logic [3:0] e_err;
        logic       e_new;
        logic [7:0] e_tx;
        logic [7:0] e_rx;
        logic [7:0] e_cr1;
    } vec_t;

    vec_t tbl [8];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b, expected %b", nm, act, exp);
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic check_reset_vals(input string nm);
        chk4({nm, " gnt"}, gnt_out, 4'b0000);
        chk4({nm, " ss"}, ss_n_out, 4'b1111);
        chk4({nm, " ack"}, ack_out, 4'b0000);
        chk4({nm, " err"}, err_out, 4'b0000);
        chk1({nm, " new"}, new_tx_out, 1'b0);
        chk8({nm, " tx"}, tx_data_out, 8'h00);
        chk8({nm, " rx"}, rx_data_out, 8'h00);
        chk8({nm, " cr1"}, spi_cr1_out, 8'h00);
    endtask

    task automatic do_reset();
        rst_in      = 1'b1;
        req_in      = '0;
        last_in     = '0;
        finished_in = 1'b0;
        master_rx_in = '0;
        step();
        step();
        rst_in = 1'b0;
    endtask

    task automatic wait_gnt(input string nm);
        int n = 0;
        while (gnt_out == 4'b0000 && n < 20) begin
            step();
            n++;
        end
        if (gnt_out == 4'b0000) begin
            chk_cnt++;
            $display("FAIL %s wait_gnt: no grant after %0d cycles, expected a grant", nm, n);
        end
    endtask

    task automatic wait_new(input string nm);
        int n = 0;
        while (new_tx_out !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (new_tx_out !== 1'b1) begin
            chk_cnt++;
            $display("FAIL %s wait_new: no new_tx after %0d cycles, expected a pulse", nm, n);
        end
    endtask

    // One single-byte transaction with a grant, start pulse, completion and release
    task automatic do_txn(input string nm, input logic [3:0] eg, input logic [7:0] etx,
                          input logic [7:0] ecr1, input logic [7:0] rxb);
        wait_gnt(nm);
        chk4({nm, " gnt"}, gnt_out, eg);
        chk4({nm, " ss"}, ss_n_out, ~eg);
        chk8({nm, " cr1"}, spi_cr1_out, ecr1);
        wait_new(nm);
        chk8({nm, " tx"}, tx_data_out, etx);
        step();
        chk1({nm, " new width"}, new_tx_out, 1'b0);
        finished_in  = 1'b1;
        master_rx_in = rxb;
        step();
        finished_in  = 1'b0;
        chk4({nm, " ack"}, ack_out, eg);
        chk8({nm, " rx"}, rx_data_out, rxb);
        step();
        chk4({nm, " ss release"}, ss_n_out, 4'b1111);
        chk4({nm, " ack end"}, ack_out, 4'b0000);
    endtask

    initial begin
        logic [7:0] bb [3];
        logic [7:0] br [3];
        logic       seen;

        data_in = {8'h44, 8'hA5, 8'h22, 8'h11};
        cr1_in  = {8'h00, 8'h08, 8'h2A, 8'h15};

        do_reset();
        check_reset_vals("reset");

        // Single requester 2, with a stray finished_in during SETUP
        tbl[0] = '{4'b0100, 4'b0100, 1'b0, 8'h00, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00, 8'hC8};
        tbl[1] = '{4'b0100, 4'b0100, 1'b1, 8'h77, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00, 8'hC8};
        tbl[2] = '{4'b0100, 4'b0100, 1'b0, 8'h00, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 1'b0, 8'h00, 8'h00, 8'hC8};
        tbl[3] = '{4'b0100, 4'b0100, 1'b0, 8'h00, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 1'b1, 8'hA5, 8'h00, 8'hC8};
        tbl[4] = '{4'b0100, 4'b0100, 1'b0, 8'h00, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 1'b0, 8'hA5, 8'h00, 8'hC8};
        tbl[5] = '{4'b0100, 4'b0100, 1'b1, 8'h3C, 4'b0100, 4'b1011, 4'b0100, 4'b0000, 1'b0, 8'hA5, 8'h3C, 8'hC8};
        tbl[6] = '{4'b0000, 4'b0100, 1'b0, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 8'hA5, 8'h3C, 8'hC8};
        tbl[7] = '{4'b0000, 4'b0100, 1'b0, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0, 8'hA5, 8'h3C, 8'hC8};

        for (int i = 0; i < 8; i++) begin
            req_in       = tbl[i].req;
            last_in      = tbl[i].last;
            finished_in  = tbl[i].fin;
            master_rx_in = tbl[i].mrx;
            step();
            chk4($sformatf("v%0d gnt", i), gnt_out, tbl[i].e_gnt);
            chk4($sformatf("v%0d ss", i), ss_n_out, tbl[i].e_ss);
            chk4($sformatf("v%0d ack", i), ack_out, tbl[i].e_ack);
            chk4($sformatf("v%0d err", i), err_out, tbl[i].e_err);
            chk1($sformatf("v%0d new", i), new_tx_out, tbl[i].e_new);
            chk8($sformatf("v%0d tx", i), tx_data_out, tbl[i].e_tx);
            chk8($sformatf("v%0d rx", i), rx_data_out, tbl[i].e_rx);
            chk8($sformatf("v%0d cr1", i), spi_cr1_out, tbl[i].e_cr1);
        end
        finished_in = 1'b0;

        // Fairness: all requesting from rr_ptr=0, order 0,1,2,3,0
        do_reset();
        req_in  = 4'b1111;
        last_in = 4'b1111;
        do_txn("rr0", 4'b0001, 8'h11, 8'hD5, 8'h90);
        do_txn("rr1", 4'b0010, 8'h22, 8'hEA, 8'h91);
        do_txn("rr2", 4'b0100, 8'hA5, 8'hC8, 8'h92);
        do_txn("rr3", 4'b1000, 8'h44, 8'hC0, 8'h93);
        do_txn("rr4", 4'b0001, 8'h11, 8'hD5, 8'h94);
        req_in = 4'b0000;

        // Burst: requester 1, three bytes, last = 0,0,1
        bb = '{8'h30, 8'h31, 8'h32};
        br = '{8'hB0, 8'hB1, 8'hB2};
        data_in[15:8] = bb[0];
        req_in  = 4'b0010;
        last_in = 4'b0000;
        wait_gnt("burst");
        chk4("burst gnt", gnt_out, 4'b0010);
        wait_new("burst");
        for (int b = 0; b < 3; b++) begin
            chk8($sformatf("burst%0d tx", b), tx_data_out, bb[b]);
            if (b < 2) data_in[15:8] = bb[b+1];
            if (b == 1) last_in = 4'b0010;
            step();
            chk1($sformatf("burst%0d new width", b), new_tx_out, 1'b0);
            finished_in  = 1'b1;
            master_rx_in = br[b];
            step();
            finished_in  = 1'b0;
            chk4($sformatf("burst%0d ack", b), ack_out, 4'b0010);
            chk8($sformatf("burst%0d rx", b), rx_data_out, br[b]);
            chk4($sformatf("burst%0d ss done", b), ss_n_out, 4'b1101);
            if (b < 2) begin
                step();
                chk1($sformatf("burst%0d gap new", b), new_tx_out, 1'b0);
                chk4($sformatf("burst%0d ss start", b), ss_n_out, 4'b1101);
                step();
                chk1($sformatf("burst%0d next new", b), new_tx_out, 1'b1);
                chk4($sformatf("burst%0d ss pulse", b), ss_n_out, 4'b1101);
            end else begin
                step();
                chk4("burst ss release", ss_n_out, 4'b1111);
                req_in = 4'b0000;
            end
        end

        // Timeout: rr_ptr=2, requesters 0 and 3 -> 3 wins, times out, then 0
        req_in  = 4'b1001;
        last_in = 4'b1001;
        wait_gnt("to");
        chk4("to gnt", gnt_out, 4'b1000);
        chk8("to cr1 forced", spi_cr1_out, 8'hC0);
        wait_new("to");
        chk8("to tx", tx_data_out, 8'h44);
        for (int k = 1; k <= 15; k++) begin
            step();
            if (k == 14) chk4("to err early", err_out, 4'b0000);
        end
        chk4("to err", err_out, 4'b1000);
        chk4("to ss release", ss_n_out, 4'b1111);
        chk4("to gnt drop", gnt_out, 4'b0000);
        step();
        chk4("to err width", err_out, 4'b0000);
        chk4("to next gnt", gnt_out, 4'b0001);
        chk4("to next ss", ss_n_out, 4'b1110);

        // Abort: owner 0 drops its request during SETUP
        req_in = 4'b0000;
        step();
        chk4("abort ss", ss_n_out, 4'b1111);
        chk4("abort gnt", gnt_out, 4'b0000);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (new_tx_out || ack_out != 4'b0000) seen = 1'b1;
        end
        chk1("abort no new/ack", seen, 1'b0);

        // Reset during BUSY, then a late finished_in
        req_in  = 4'b0100;
        last_in = 4'b0100;
        wait_gnt("rst");
        chk4("rst gnt", gnt_out, 4'b0100);
        wait_new("rst");
        step();
        rst_in = 1'b1;
        req_in = 4'b0000;
        step();
        rst_in = 1'b0;
        check_reset_vals("rst busy");
        finished_in  = 1'b1;
        master_rx_in = 8'hFF;
        step();
        finished_in  = 1'b0;
        chk4("late fin ack", ack_out, 4'b0000);
        chk8("late fin rx", rx_data_out, 8'h00);
        chk4("late fin gnt", gnt_out, 4'b0000);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
